// File: rtl/fir16_out_stage.sv
// Output conditioning for the 16-tap FIR: valid realignment, warm-up discard, decimation,
// Q6.30 -> Q1.15 round/saturate and a small FWFT FIFO. Define FIR16_OUT_STATS_EN for counters.
module fir16_out_stage #(
    parameter int LAT     = 3,
    parameter int WARMUP  = 15,
    parameter int DECIM   = 1,
    parameter int FIFO_AW = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [35:0] y_in,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    output logic        sat_flag
`ifdef FIR16_OUT_STATS_EN
    ,
    output logic [15:0] sat_count,
    output logic [15:0] drop_count
`endif
);

    localparam int WW    = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    localparam int DW    = (DECIM <= 1) ? 1 : $clog2(DECIM);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    logic [LAT-1:0]     vline_q, vline_d;
    logic [WW-1:0]      warm_q, warm_d;
    logic [DW-1:0]      dec_q, dec_d;
    logic [15:0]        qdata_q, qdata_d;
    logic               qvalid_q, qvalid_d;
    logic [15:0]        mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               sat_q, sat_d;

    logic        av, warm_done, post, keep, sat, full, do_pop, do_push, drop;
    logic [36:0] r;
    logic        unused_r_low;

    assign av        = vline_q[LAT-1];
    assign warm_done = (warm_q == WW'(WARMUP));
    assign post      = av & warm_done;
    assign keep      = post & (dec_q == '0);

    // Round half up at bit 14, then check that the integer bits fit a Q1.15 sign.
    assign r            = {y_in[35], y_in} + 37'd16384;
    assign sat          = !((&r[36:30]) || !(|r[36:30]));
    assign unused_r_low = ^r[14:0];

    assign full    = (cnt_q == CW'(DEPTH));
    assign do_pop  = (cnt_q != '0) & out_ready;
    assign do_push = qvalid_q & (!full | do_pop);
    assign drop    = qvalid_q & full & !do_pop;

    always_comb begin
        vline_d    = vline_q << 1;
        vline_d[0] = in_valid;

        warm_d = warm_q;
        if (av && !warm_done) begin
            warm_d = warm_q + 1'b1;
        end

        dec_d = dec_q;
        if (post) begin
            dec_d = (dec_q == DW'(DECIM - 1)) ? '0 : dec_q + 1'b1;
        end

        qvalid_d = keep;
        qdata_d  = qdata_q;
        if (keep) begin
            if (sat) begin
                qdata_d = r[36] ? 16'h8000 : 16'h7FFF;
            end else begin
                qdata_d = r[30:15];
            end
        end

        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + {{FIFO_AW{1'b0}}, do_push} - {{FIFO_AW{1'b0}}, do_pop};

        ovf_d = ovf_q | drop;
        sat_d = sat_q | (keep & sat);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vline_q  <= '0;
            warm_q   <= '0;
            dec_q    <= '0;
            qdata_q  <= '0;
            qvalid_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            sat_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            vline_q  <= vline_d;
            warm_q   <= warm_d;
            dec_q    <= dec_d;
            qdata_q  <= qdata_d;
            qvalid_q <= qvalid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            sat_q    <= sat_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= qdata_q;
            end
        end
    end

    assign out_data  = mem_q[rd_ptr_q];
    assign out_valid = (cnt_q != '0);
    assign overflow  = ovf_q;
    assign sat_flag  = sat_q;

`ifdef FIR16_OUT_STATS_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        sat_cnt_d  = sat_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (keep && sat && sat_cnt_q != 16'hFFFF) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
        if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            sat_cnt_q  <= sat_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign sat_count  = sat_cnt_q;
    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fir16_out_stage.sv
// Directed bench for fir16_out_stage: three instances cover WARMUP=0/DECIM=1, WARMUP=15 and DECIM=4.
module tb_fir16_out_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [35:0] y_in;
    logic        out_ready;

    logic [15:0] a_data, w_data, d_data;
    logic        a_valid, w_valid, d_valid;
    logic        a_ovf, w_ovf, d_ovf;
    logic        a_sat, w_sat, d_sat;
`ifdef FIR16_OUT_STATS_EN
    logic [15:0] a_sc, a_dc, w_sc, w_dc, d_sc, d_dc;
`endif

    int          sel;
    logic [15:0] obs_data;
    logic        obs_valid, obs_ovf, obs_sat;

    int          n_checks;
    int          n_fail;
    logic [35:0] y_pipe [3];
    logic [15:0] got_q [$];
    logic [15:0] exp_q [$];

    fir16_out_stage #(.LAT(3), .WARMUP(0), .DECIM(1), .FIFO_AW(2)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .y_in(y_in),
        .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready),
        .overflow(a_ovf), .sat_flag(a_sat)
`ifdef FIR16_OUT_STATS_EN
        , .sat_count(a_sc), .drop_count(a_dc)
`endif
    );

    fir16_out_stage #(.LAT(3), .WARMUP(15), .DECIM(1), .FIFO_AW(2)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .y_in(y_in),
        .out_data(w_data), .out_valid(w_valid), .out_ready(out_ready),
        .overflow(w_ovf), .sat_flag(w_sat)
`ifdef FIR16_OUT_STATS_EN
        , .sat_count(w_sc), .drop_count(w_dc)
`endif
    );

    fir16_out_stage #(.LAT(3), .WARMUP(0), .DECIM(4), .FIFO_AW(2)) dut_d (
        .clk(clk), .reset(reset), .in_valid(in_valid), .y_in(y_in),
        .out_data(d_data), .out_valid(d_valid), .out_ready(out_ready),
        .overflow(d_ovf), .sat_flag(d_sat)
`ifdef FIR16_OUT_STATS_EN
        , .sat_count(d_sc), .drop_count(d_dc)
`endif
    );

    always_comb begin
        obs_data  = a_data;
        obs_valid = a_valid;
        obs_ovf   = a_ovf;
        obs_sat   = a_sat;
        if (sel == 1) begin
            obs_data  = w_data;
            obs_valid = w_valid;
            obs_ovf   = w_ovf;
            obs_sat   = w_sat;
        end else if (sel == 2) begin
            obs_data  = d_data;
            obs_valid = d_valid;
            obs_ovf   = d_ovf;
            obs_sat   = d_sat;
        end
    end

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: drive in_valid/out_ready now, present yv three cycles later, log handshakes.
    task automatic step(input logic v, input logic [35:0] yv, input logic rdy);
        @(negedge clk);
        in_valid  = v;
        out_ready = rdy;
        y_in      = y_pipe[2];
        y_pipe[2] = y_pipe[1];
        y_pipe[1] = y_pipe[0];
        y_pipe[0] = yv;
        if (obs_valid && rdy) got_q.push_back(obs_data);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        in_valid  = 1'b0;
        y_in      = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) y_pipe[i] = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        sel   = 0;
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            y_in      = {4'($urandom_range(0, 15)), 32'($urandom)};
            out_ready = 1'($urandom_range(0, 1));
        end
        n_checks++;
        if (obs_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", obs_data); end
        n_checks++;
        if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", obs_valid); end
        n_checks++;
        if (obs_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", obs_ovf); end
        n_checks++;
        if (obs_sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b want 0", obs_sat); end
        @(negedge clk);
        in_valid = 1'b0;
        y_in     = '0;
        for (int i = 0; i < 3; i++) y_pipe[i] = '0;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 36'd0, 1'b1);
            n_checks++;
            if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: cycle %0d got %b want 0", i, obs_valid); end
        end
    endtask

    task automatic test_rounding();
        logic [35:0] yv [6];
        logic [15:0] ev [6];
        logic        es [6];
        yv[0] = 36'h000004000; ev[0] = 16'h0001; es[0] = 1'b0;
        yv[1] = 36'h000003FFF; ev[1] = 16'h0000; es[1] = 1'b0;
        yv[2] = 36'hFFFFFC000; ev[2] = 16'h0000; es[2] = 1'b0;
        yv[3] = 36'hFC0000000; ev[3] = 16'h8000; es[3] = 1'b0; // -2^30, exactly -1.0
        yv[4] = 36'h03FFFFFFF; ev[4] = 16'h7FFF; es[4] = 1'b1;
        yv[5] = 36'hF00000000; ev[5] = 16'h8000; es[5] = 1'b1;
        sel = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, yv[i], 1'b1);
            repeat (4) step(1'b0, 36'd0, 1'b1);
            n_checks++;
            if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL round_early_%0d: valid %b want 0", i, obs_valid); end
            step(1'b0, 36'd0, 1'b1);
            n_checks++;
            if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL round_latency_%0d: valid %b want 1", i, obs_valid); end
            n_checks++;
            if (obs_data !== ev[i]) begin n_fail++; $display("FAIL round_value_%0d: got %h want %h", i, obs_data, ev[i]); end
            n_checks++;
            if (obs_sat !== es[i]) begin n_fail++; $display("FAIL round_sat_%0d: got %b want %b", i, obs_sat, es[i]); end
            step(1'b0, 36'd0, 1'b1);
        end
    endtask

    task automatic test_warmup();
        sel = 1;
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 36'(i) << 15, 1'b1);
        repeat (10) step(1'b0, 36'd0, 1'b1);
        for (int i = 15; i < 20; i++) exp_q.push_back(16'(i));
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL warmup_count: got %0d outputs want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL warmup_value_%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_decimation();
        sel = 2;
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1, 36'(i) << 15, 1'b1);
        repeat (10) step(1'b0, 36'd0, 1'b1);
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd4);
        exp_q.push_back(16'd8);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL decim_count: got %0d outputs want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL decim_value_%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        sel = 0;
        do_reset();
        for (int i = 1; i <= 6; i++) step(1'b1, 36'(i) << 15, 1'b0);
        repeat (3) step(1'b0, 36'd0, 1'b0);
        n_checks++;
        if (obs_valid !== 1'b1 || obs_ovf !== 1'b0) begin
            n_fail++; $display("FAIL bp_before_drop: valid %b ovf %b want 1 0", obs_valid, obs_ovf);
        end
        step(1'b0, 36'd0, 1'b0);
        n_checks++;
        if (obs_valid !== 1'b1 || obs_ovf !== 1'b1) begin
            n_fail++; $display("FAIL bp_overflow: valid %b ovf %b want 1 1", obs_valid, obs_ovf);
        end
        repeat (2) step(1'b0, 36'd0, 1'b0);
        repeat (8) step(1'b0, 36'd0, 1'b1);
        for (int i = 1; i <= 4; i++) exp_q.push_back(16'(i));
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL bp_count: got %0d outputs want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL bp_value_%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
            end
        end
        n_checks++;
        if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: valid %b want 0", obs_valid); end
    endtask

    task automatic test_full_push_pop();
        sel = 0;
        do_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, 36'(i) << 15, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 36'd0, 1'b1);
            n_checks++;
            if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid_%0d: valid %b want 1", i, obs_valid); end
        end
        repeat (8) step(1'b0, 36'd0, 1'b1);
        for (int i = 1; i <= 8; i++) exp_q.push_back(16'(i));
        n_checks++;
        if (obs_ovf !== 1'b0) begin n_fail++; $display("FAIL full_no_drop: ovf %b want 0", obs_ovf); end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL full_count: got %0d outputs want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL full_value_%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        sel = 1;
        do_reset();
        for (int i = 0; i < 22; i++) step(1'b1, 36'(i) << 15, 1'b0);
        repeat (3) step(1'b0, 36'd0, 1'b0);
        n_checks++;
        if (obs_valid !== 1'b1 || obs_ovf !== 1'b1) begin
            n_fail++; $display("FAIL mid_before: valid %b ovf %b want 1 1", obs_valid, obs_ovf);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (obs_valid !== 1'b0 || obs_data !== 16'h0000 || obs_ovf !== 1'b0 || obs_sat !== 1'b0) begin
            n_fail++; $display("FAIL mid_flush: valid %b data %h ovf %b sat %b want 0 0000 0 0", obs_valid, obs_data, obs_ovf, obs_sat);
        end
        for (int i = 0; i < 3; i++) y_pipe[i] = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 17; i++) step(1'b1, 36'(i) << 15, 1'b1);
        repeat (10) step(1'b0, 36'd0, 1'b1);
        exp_q.push_back(16'd15);
        exp_q.push_back(16'd16);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL mid_count: got %0d outputs want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL mid_value_%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        sel       = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        y_in      = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) y_pipe[i] = '0;
        test_reset();
        test_rounding();
        test_warmup();
        test_decimation();
        test_backpressure();
        test_full_push_pop();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
